dea_stream_cipher: RTL and testbench
====================================

Name: dea_stream_cipher

Overview:
- Parametrised, packet-framed XOR stream cipher engine. Sits between UART_Receiver and UART_Sender in the DEA top level.
- Receives, byte by byte: data length, data, key length, key. Encrypts data with the cyclically repeated key.
- Transmits the length byte, then the ciphertext. Keeps plaintext and ciphertext buffered for LED display.
- Adds length checking, an error flag and a completion flag, and is back-to-back packet capable.

Parameters:
MAX_DATA, 100, data buffer depth in bytes (1..255)
MAX_KEY, 8, key buffer depth in bytes (1..255)
ECHO_LEN, 1, 1 = send the length byte before the ciphertext; 0 = ciphertext only
IDXW, 8, width of the display index (ceil(log2(MAX_DATA)) or more)

Ports:
Clk_100M  in  1  system clock
Reset  in  1  asynchronous, active-low reset
Rx_Data  in  8  byte from UART_Receiver
Rx_Ready  in  1  receiver has a byte
Rx_Ack  out  1  byte consumed
Tx_Data  out  8  byte to UART_Sender
Tx_Send  out  1  request transmit
Tx_Busy  in  1  sender busy
Disp_Index  in  IDXW  byte selected for display
Disp_Plain  out  8  plaintext at Disp_Index
Disp_Cipher  out  8  ciphertext at Disp_Index
Busy  out  1  packet in progress (any state other than IDLE)
Done  out  1  last packet fully transmitted (sticky)
Error  out  1  last length byte was invalid (sticky)

Behaviour:
- Reset (Reset=0, asynchronous):
  - State IDLE.
  - Rx_Ack=0, Tx_Send=0, Tx_Data=0, Busy=0, Done=0, Error=0.
  - All counters 0. Buffer contents undefined; Disp_* read 0 until the first packet has been received.
- Reset asserted mid-packet: abort immediately, no partial Tx continues, and the next byte is treated as a length byte.
- Rx handshake:
  - A byte is taken on the cycle where Rx_Ready=1 and Rx_Ack=0. Rx_Ack rises on the next edge.
  - Rx_Ack stays 1 until Rx_Ready=0, then falls on the next edge.
  - Exactly one byte is consumed per Rx_Ready pulse.
- Tx handshake:
  - When the controller has a byte and Tx_Busy=0 and Tx_Send=0: drive Tx_Data, set Tx_Send=1.
  - Hold both until Tx_Busy=1, then Tx_Send=0.
  - The next byte is not offered until Tx_Busy=0.
  - The Tx byte index advances exactly once per accepted byte.
- States:
  - IDLE: received byte L. If 1<=L<=MAX_DATA: latch L, clear Error and Done, go RX_DATA. Else set Error=1 and stay IDLE.
  - RX_DATA: data[i]<=byte, i++. After byte L-1 go RX_KLEN.
  - RX_KLEN: received byte K. If 1<=K<=MAX_KEY: latch K, go RX_KEY. Else set Error=1 and go IDLE (packet discarded).
  - RX_KEY: key[j]<=byte, j++. After byte K-1 go ENC.
  - ENC: one byte per cycle, cipher[i]=data[i]^key[i mod K]. The key index wraps K-1 to 0 without a divider. Lasts exactly L cycles, then go TX_LEN if ECHO_LEN=1, else TX_DATA.
  - TX_LEN: send L, then go TX_DATA.
  - TX_DATA: send cipher[0..L-1] in order. After the last byte is accepted (Tx_Busy seen high), set Done=1 and go IDLE.
- Rx bytes arriving in ENC/TX_LEN/TX_DATA are not acknowledged; Rx_Ack is held 0 and the receiver keeps them.
- Display:
  - Combinational reads of the buffers.
  - If Disp_Index >= L of the last valid packet, Disp_Plain and Disp_Cipher read 0.
  - The display keeps showing the previous packet until a new packet reaches ENC. Plaintext updates during RX_DATA.
- Width rules:
  - Counters are 8 bits. Comparisons are against L-1 and K-1 with L,K>=1, so there is no underflow.
- Simultaneous events: Rx acceptance and Tx request are never both active, because the states are exclusive.

Decomposition:
- Package dea_pkg:
  - State enum (IDLE, RX_DATA, RX_KLEN, RX_KEY, ENC, TX_LEN, TX_DATA).
  - Byte width constant (8).
  - Default MAX_DATA and MAX_KEY.
- One sub-module, dea_tx_handshake: byte-offer FSM around Tx_Send/Tx_Busy, with a byte-accepted pulse to the controller.
- Buffers are inferred arrays in the top block.

Test Plan:
- Rx 0x03,'A','B','C',0x02,0x01,0x02 -> Tx 0x03,0x40,0x40,0x42; Done=1; Disp_Index=2 gives Plain 0x43, Cipher 0x42.
- Rx 0x00 then 0x65 (MAX_DATA=100) -> Error=1 each time, no Tx, stays IDLE. Then a valid packet clears Error.
- L=5, K=0x09 (MAX_KEY=8) -> Error=1, back in IDLE. The next byte 0x01 is taken as a new length.
- L=4, K=1, key 0xFF, data 0x00,0x0F,0xF0,0xAA -> Tx 0x04,0xFF,0xF0,0x0F,0x55. ECHO_LEN=0 build omits the leading 0x04.
- Hold Tx_Busy=1 for 500 cycles after the first Tx_Send -> Tx_Send drops once, no byte skipped or duplicated. Rx bytes sent during TX_DATA are not acked until IDLE.
- Pull Reset low during RX_DATA byte 2 -> all outputs at reset values asynchronously. Then a fresh packet 0x01,0x55,0x01,0x55 -> Tx 0x01,0x00.

Source files
------------

// File: rtl/dea_pkg.sv
// Shared types and constants for the DEA XOR stream cipher engine.
package dea_pkg;
    localparam int BYTE_W       = 8;
    localparam int DEF_MAX_DATA = 100;
    localparam int DEF_MAX_KEY  = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_DATA = 3'd1,
        RX_KLEN = 3'd2,
        RX_KEY  = 3'd3,
        ENC     = 3'd4,
        TX_LEN  = 3'd5,
        TX_DATA = 3'd6
    } dea_state_t;

    // A length byte is usable when it is non-zero and fits the buffer.
    function automatic logic len_ok(input logic [BYTE_W-1:0] v, input logic [BYTE_W-1:0] max_v);
        len_ok = (v != 8'd0) && (v <= max_v);
    endfunction
endpackage

// File: rtl/dea_tx_handshake.sv
// Offers one byte at a time to the UART sender and pulses o_accept once the
// sender has taken it (Tx_Busy seen high).
module dea_tx_handshake
    import dea_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_tx_busy,
    output logic [BYTE_W-1:0] o_tx_data,
    output logic              o_tx_send,
    output logic              o_accept
);
    typedef enum logic [1:0] {
        HS_READY     = 2'd0,
        HS_WAIT_BUSY = 2'd1,
        HS_WAIT_FREE = 2'd2
    } hs_state_t;

    hs_state_t         r_state;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_tx_send;
    logic              r_accept;

    // Offer / wait-for-busy / wait-for-idle sequencing of one byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= HS_READY;
            r_tx_data <= 8'd0;
            r_tx_send <= 1'b0;
            r_accept  <= 1'b0;
        end else begin
            r_accept <= 1'b0;
            case (r_state)
                HS_READY: begin
                    if (i_valid && !i_tx_busy && !r_tx_send) begin
                        r_tx_data <= i_byte;
                        r_tx_send <= 1'b1;
                        r_state   <= HS_WAIT_BUSY;
                    end
                end
                HS_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_tx_send <= 1'b0;
                        r_accept  <= 1'b1;
                        r_state   <= HS_WAIT_FREE;
                    end
                end
                HS_WAIT_FREE: begin
                    if (!i_tx_busy) begin
                        r_state <= HS_READY;
                    end
                end
                default: begin
                    r_tx_send <= 1'b0;
                    r_state   <= HS_READY;
                end
            endcase
        end
    end

    assign o_tx_data = r_tx_data;
    assign o_tx_send = r_tx_send;
    assign o_accept  = r_accept;
endmodule

// File: rtl/dea_stream_cipher.sv
// Packet-framed XOR stream cipher: receives length/data/key-length/key bytes,
// encrypts with the repeated key and transmits length plus ciphertext.
module dea_stream_cipher
    import dea_pkg::*;
#(
    parameter int MAX_DATA = DEF_MAX_DATA,
    parameter int MAX_KEY  = DEF_MAX_KEY,
    parameter int ECHO_LEN = 1,
    parameter int IDXW     = 8
) (
    input  logic              Clk_100M,
    input  logic              Reset,
    input  logic [BYTE_W-1:0] Rx_Data,
    input  logic              Rx_Ready,
    output logic              Rx_Ack,
    output logic [BYTE_W-1:0] Tx_Data,
    output logic              Tx_Send,
    input  logic              Tx_Busy,
    input  logic [IDXW-1:0]   Disp_Index,
    output logic [BYTE_W-1:0] Disp_Plain,
    output logic [BYTE_W-1:0] Disp_Cipher,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);
    localparam int DAW = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;
    localparam int KAW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;
    localparam logic [BYTE_W-1:0] MAX_DATA_B = 8'(MAX_DATA);
    localparam logic [BYTE_W-1:0] MAX_KEY_B  = 8'(MAX_KEY);

    dea_state_t        r_state;
    logic [BYTE_W-1:0] r_len, r_klen, r_idx, r_kidx, r_disp_len;
    logic              r_rx_ack, r_busy, r_done, r_error;

    logic [BYTE_W-1:0] r_data_mem   [0:(1<<DAW)-1];
    logic [BYTE_W-1:0] r_cipher_mem [0:(1<<DAW)-1];
    logic [BYTE_W-1:0] r_key_mem    [0:(1<<KAW)-1];

    logic              w_rx_take, w_tx_valid, w_accept;
    logic [BYTE_W-1:0] w_tx_byte, w_disp_plain, w_disp_cipher;

    assign w_rx_take  = Rx_Ready && !r_rx_ack && (r_state inside {IDLE, RX_DATA, RX_KLEN, RX_KEY});
    assign w_tx_valid = (r_state == TX_LEN) || (r_state == TX_DATA);
    assign w_tx_byte  = (r_state == TX_LEN) ? r_len : r_cipher_mem[r_idx[DAW-1:0]];

    // Packet controller: framing, counters, status flags and Rx acknowledge.
    always_ff @(posedge Clk_100M or negedge Reset) begin
        if (!Reset) begin
            r_state    <= IDLE;
            r_len      <= 8'd0;
            r_klen     <= 8'd0;
            r_idx      <= 8'd0;
            r_kidx     <= 8'd0;
            r_disp_len <= 8'd0;
            r_rx_ack   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_rx_take) begin
                r_rx_ack <= 1'b1;
            end else if (!Rx_Ready) begin
                r_rx_ack <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_rx_take) begin
                        if (len_ok(Rx_Data, MAX_DATA_B)) begin
                            r_len   <= Rx_Data;
                            r_idx   <= 8'd0;
                            r_error <= 1'b0;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= RX_DATA;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_take) begin
                        if (r_idx == r_len - 8'd1) begin
                            r_idx   <= 8'd0;
                            r_state <= RX_KLEN;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                RX_KLEN: begin
                    if (w_rx_take) begin
                        if (len_ok(Rx_Data, MAX_KEY_B)) begin
                            r_klen  <= Rx_Data;
                            r_kidx  <= 8'd0;
                            r_state <= RX_KEY;
                        end else begin
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                RX_KEY: begin
                    if (w_rx_take) begin
                        if (r_kidx == r_klen - 8'd1) begin
                            r_kidx     <= 8'd0;
                            r_idx      <= 8'd0;
                            r_disp_len <= r_len;
                            r_state    <= ENC;
                        end else begin
                            r_kidx <= r_kidx + 8'd1;
                        end
                    end
                end
                ENC: begin
                    // Key index wraps by compare so no modulo is needed.
                    r_kidx <= (r_kidx == r_klen - 8'd1) ? 8'd0 : r_kidx + 8'd1;
                    if (r_idx == r_len - 8'd1) begin
                        r_idx   <= 8'd0;
                        r_state <= (ECHO_LEN != 0) ? TX_LEN : TX_DATA;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                    end
                end
                TX_LEN: begin
                    if (w_accept) begin
                        r_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (w_accept) begin
                        if (r_idx == r_len - 8'd1) begin
                            r_idx   <= 8'd0;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Byte buffers; contents are don't-care until written, so no reset.
    always_ff @(posedge Clk_100M) begin
        if (w_rx_take && (r_state == RX_DATA)) begin
            r_data_mem[r_idx[DAW-1:0]] <= Rx_Data;
        end
        if (w_rx_take && (r_state == RX_KEY)) begin
            r_key_mem[r_kidx[KAW-1:0]] <= Rx_Data;
        end
        if (r_state == ENC) begin
            r_cipher_mem[r_idx[DAW-1:0]] <= r_data_mem[r_idx[DAW-1:0]] ^ r_key_mem[r_kidx[KAW-1:0]];
        end
    end

    // Display read-out, blanked beyond the last valid packet length.
    always_comb begin
        w_disp_plain  = 8'd0;
        w_disp_cipher = 8'd0;
        if (int'(Disp_Index) < int'(r_disp_len)) begin
            w_disp_plain  = r_data_mem[Disp_Index[DAW-1:0]];
            w_disp_cipher = r_cipher_mem[Disp_Index[DAW-1:0]];
        end else begin
            w_disp_plain  = 8'd0;
            w_disp_cipher = 8'd0;
        end
    end

    dea_tx_handshake u_tx_hs (
        .i_clk     (Clk_100M),
        .i_rst_n   (Reset),
        .i_valid   (w_tx_valid),
        .i_byte    (w_tx_byte),
        .i_tx_busy (Tx_Busy),
        .o_tx_data (Tx_Data),
        .o_tx_send (Tx_Send),
        .o_accept  (w_accept)
    );

    assign Rx_Ack      = r_rx_ack;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Error       = r_error;
    assign Disp_Plain  = w_disp_plain;
    assign Disp_Cipher = w_disp_cipher;
endmodule

// File: tb/tb_dea_stream_cipher.sv
// Directed bench for dea_stream_cipher: packet vectors table plus corner sequences.
module tb_dea_stream_cipher;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] disp_idx = 8'd0;

    logic [7:0] rx_data1 = 8'd0, rx_data2 = 8'd0;
    logic       rx_ready1 = 1'b0, rx_ready2 = 1'b0;
    logic       rx_ack1, rx_ack2;
    logic [7:0] tx_data1, tx_data2;
    logic       tx_send1, tx_send2;
    logic       tx_busy1 = 1'b0, tx_busy2 = 1'b0;
    logic [7:0] plain1, cipher1, plain2, cipher2;
    logic       busy1, done1, error1, busy2, done2, error2;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cycles1 = 3;
    int busy_cycles2 = 3;
    int send_rises1 = 0;
    logic [7:0] txq1 [$];
    logic [7:0] txq2 [$];

    always #5 clk = ~clk;

    dea_stream_cipher #(.MAX_DATA(100), .MAX_KEY(8), .ECHO_LEN(1), .IDXW(8)) dut1 (
        .Clk_100M(clk), .Reset(rst_n), .Rx_Data(rx_data1), .Rx_Ready(rx_ready1), .Rx_Ack(rx_ack1),
        .Tx_Data(tx_data1), .Tx_Send(tx_send1), .Tx_Busy(tx_busy1), .Disp_Index(disp_idx),
        .Disp_Plain(plain1), .Disp_Cipher(cipher1), .Busy(busy1), .Done(done1), .Error(error1));

    dea_stream_cipher #(.MAX_DATA(100), .MAX_KEY(8), .ECHO_LEN(0), .IDXW(8)) dut2 (
        .Clk_100M(clk), .Reset(rst_n), .Rx_Data(rx_data2), .Rx_Ready(rx_ready2), .Rx_Ack(rx_ack2),
        .Tx_Data(tx_data2), .Tx_Send(tx_send2), .Tx_Busy(tx_busy2), .Disp_Index(disp_idx),
        .Disp_Plain(plain2), .Disp_Cipher(cipher2), .Busy(busy2), .Done(done2), .Error(error2));

    // UART sender models: capture a byte on Tx_Send, then stay busy for a while.
    initial begin : sender1
        forever begin
            @(negedge clk);
            if (tx_send1) begin
                txq1.push_back(tx_data1);
                tx_busy1 = 1'b1;
                repeat (busy_cycles1) @(negedge clk);
                tx_busy1 = 1'b0;
            end
        end
    end

    initial begin : sender2
        forever begin
            @(negedge clk);
            if (tx_send2) begin
                txq2.push_back(tx_data2);
                tx_busy2 = 1'b1;
                repeat (busy_cycles2) @(negedge clk);
                tx_busy2 = 1'b0;
            end
        end
    end

    initial begin : rise_counter
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send1 && !prev) send_rises1++;
            prev = tx_send1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx_byte(input int which, input logic [7:0] b);
        int t;
        @(negedge clk);
        if (which == 1) begin rx_data1 = b; rx_ready1 = 1'b1; end
        else begin rx_data2 = b; rx_ready2 = 1'b1; end
        t = 0;
        while (((which == 1) ? rx_ack1 : rx_ack2) !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("rx_ack rise byte 0x%02h", b), (which == 1) ? rx_ack1 : rx_ack2, 1'b1);
        if (which == 1) rx_ready1 = 1'b0; else rx_ready2 = 1'b0;
        t = 0;
        while (((which == 1) ? rx_ack1 : rx_ack2) !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("rx_ack fall byte 0x%02h", b), (which == 1) ? rx_ack1 : rx_ack2, 1'b0);
    endtask

    task automatic wait_done(input int which, input int bound, input string name);
        int t;
        t = 0;
        while (!((which == 1) ? (done1 && !busy1) : (done2 && !busy2)) && t < bound) begin
            @(negedge clk);
            t++;
        end
        check({name, " done"}, (which == 1) ? done1 : done2, 1'b1);
    endtask

    typedef struct {
        logic [7:0] rx [0:7];
        int         nrx;
        logic [7:0] tx [0:7];
        int         ntx;
        logic       exp_err;
        logic       exp_done;
        logic [7:0] didx;
        logic [7:0] exp_plain;
        logic [7:0] exp_cipher;
    } vec_t;

    vec_t vecs [0:5];

    initial begin : main
        int t;
        logic ack_seen;
        logic [7:0] exp_b;

        vecs[0].rx = '{8'h03, 8'h41, 8'h42, 8'h43, 8'h02, 8'h01, 8'h02, 8'h00}; vecs[0].nrx = 7;
        vecs[0].tx = '{8'h03, 8'h40, 8'h40, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[0].ntx = 4;
        vecs[0].exp_err = 1'b0; vecs[0].exp_done = 1'b1;
        vecs[0].didx = 8'd2; vecs[0].exp_plain = 8'h43; vecs[0].exp_cipher = 8'h42;

        vecs[1].rx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[1].nrx = 1;
        vecs[1].tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[1].ntx = 0;
        vecs[1].exp_err = 1'b1; vecs[1].exp_done = 1'b1;
        vecs[1].didx = 8'd2; vecs[1].exp_plain = 8'h43; vecs[1].exp_cipher = 8'h42;

        vecs[2].rx = '{8'h65, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].nrx = 1;
        vecs[2].tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[2].ntx = 0;
        vecs[2].exp_err = 1'b1; vecs[2].exp_done = 1'b1;
        vecs[2].didx = 8'd3; vecs[2].exp_plain = 8'h00; vecs[2].exp_cipher = 8'h00;

        vecs[3].rx = '{8'h04, 8'h00, 8'h0F, 8'hF0, 8'hAA, 8'h01, 8'hFF, 8'h00}; vecs[3].nrx = 7;
        vecs[3].tx = '{8'h04, 8'hFF, 8'hF0, 8'h0F, 8'h55, 8'h00, 8'h00, 8'h00}; vecs[3].ntx = 5;
        vecs[3].exp_err = 1'b0; vecs[3].exp_done = 1'b1;
        vecs[3].didx = 8'd3; vecs[3].exp_plain = 8'hAA; vecs[3].exp_cipher = 8'h55;

        vecs[4].rx = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h09, 8'h00}; vecs[4].nrx = 7;
        vecs[4].tx = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[4].ntx = 0;
        vecs[4].exp_err = 1'b1; vecs[4].exp_done = 1'b0;
        vecs[4].didx = 8'd3; vecs[4].exp_plain = 8'h44; vecs[4].exp_cipher = 8'h55;

        vecs[5].rx = '{8'h01, 8'h7E, 8'h01, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[5].nrx = 4;
        vecs[5].tx = '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; vecs[5].ntx = 2;
        vecs[5].exp_err = 1'b0; vecs[5].exp_done = 1'b1;
        vecs[5].didx = 8'd0; vecs[5].exp_plain = 8'h7E; vecs[5].exp_cipher = 8'hFF;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", busy1, 1'b0);
        check("reset done", done1, 1'b0);
        check("reset error", error1, 1'b0);
        check("reset rx_ack", rx_ack1, 1'b0);
        check("reset tx_send", tx_send1, 1'b0);
        check("reset tx_data", tx_data1, 8'h00);
        check("reset disp_plain", plain1, 8'h00);
        check("reset disp_cipher", cipher1, 8'h00);
        check("reset dut2 busy", busy2, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven packets
        for (int v = 0; v < 6; v++) begin
            txq1.delete();
            for (int k = 0; k < vecs[v].nrx; k++) rx_byte(1, vecs[v].rx[k]);
            if (vecs[v].ntx > 0) wait_done(1, 3000, $sformatf("v%0d", v));
            else repeat (10) @(negedge clk);
            check($sformatf("v%0d tx_count", v), txq1.size(), vecs[v].ntx);
            for (int k = 0; k < vecs[v].ntx && k < txq1.size(); k++)
                check($sformatf("v%0d tx_byte[%0d]", v, k), txq1[k], vecs[v].tx[k]);
            check($sformatf("v%0d error", v), error1, vecs[v].exp_err);
            check($sformatf("v%0d done", v), done1, vecs[v].exp_done);
            check($sformatf("v%0d busy", v), busy1, 1'b0);
            disp_idx = vecs[v].didx;
            #1;
            check($sformatf("v%0d disp_plain", v), plain1, vecs[v].exp_plain);
            check($sformatf("v%0d disp_cipher", v), cipher1, vecs[v].exp_cipher);
        end

        // Boundary: L=100, K=8
        txq1.delete();
        rx_byte(1, 8'd100);
        for (int i = 0; i < 100; i++) rx_byte(1, 8'(i));
        rx_byte(1, 8'd8);
        for (int j = 0; j < 8; j++) rx_byte(1, 8'hA0 + 8'(j));
        wait_done(1, 5000, "max_len");
        check("max_len tx_count", txq1.size(), 101);
        if (txq1.size() == 101) begin
            check("max_len tx_len", txq1[0], 8'd100);
            for (int i = 0; i < 100; i++) begin
                exp_b = 8'(i) ^ (8'hA0 + 8'(i % 8));
                check($sformatf("max_len tx_byte[%0d]", i), txq1[i+1], exp_b);
            end
        end
        disp_idx = 8'd99;
        #1;
        check("max_len disp_plain 99", plain1, 8'h63);
        check("max_len disp_cipher 99", cipher1, 8'hC0);
        disp_idx = 8'd100;
        #1;
        check("max_len disp_plain 100", plain1, 8'h00);

        // Tx_Busy held for 500 cycles; Rx byte offered during TX_DATA
        txq1.delete();
        busy_cycles1 = 500;
        send_rises1 = 0;
        for (int k = 0; k < vecs[0].nrx; k++) rx_byte(1, vecs[0].rx[k]);
        t = 0;
        while (!tx_send1 && t < 200) begin @(negedge clk); t++; end
        check("hold first send", tx_send1, 1'b1);
        repeat (20) @(negedge clk);
        busy_cycles1 = 3;
        check("hold send dropped", tx_send1, 1'b0);
        check("hold busy", busy1, 1'b1);
        rx_data1 = 8'h00;
        rx_ready1 = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rx_ack1) ack_seen = 1'b1;
        end
        check("hold no rx_ack in tx", ack_seen, 1'b0);
        wait_done(1, 3000, "hold");
        check("hold tx_count", txq1.size(), 4);
        for (int k = 0; k < 4 && k < txq1.size(); k++)
            check($sformatf("hold tx_byte[%0d]", k), txq1[k], vecs[0].tx[k]);
        check("hold send_rises", send_rises1, 4);
        t = 0;
        while (!rx_ack1 && t < 200) begin @(negedge clk); t++; end
        check("hold rx_ack after idle", rx_ack1, 1'b1);
        rx_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        check("hold late byte as length", error1, 1'b1);
        check("hold late rx_ack fall", rx_ack1, 1'b0);

        // Asynchronous reset in the middle of RX_DATA
        txq1.delete();
        rx_byte(1, 8'h05);
        rx_byte(1, 8'h11);
        rx_byte(1, 8'h22);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", busy1, 1'b0);
        check("midrst done", done1, 1'b0);
        check("midrst error", error1, 1'b0);
        check("midrst rx_ack", rx_ack1, 1'b0);
        check("midrst tx_send", tx_send1, 1'b0);
        check("midrst tx_data", tx_data1, 8'h00);
        disp_idx = 8'd0;
        #1;
        check("midrst disp_plain", plain1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_byte(1, 8'h01);
        rx_byte(1, 8'h55);
        rx_byte(1, 8'h01);
        rx_byte(1, 8'h55);
        wait_done(1, 3000, "post_rst");
        check("post_rst tx_count", txq1.size(), 2);
        if (txq1.size() == 2) begin
            check("post_rst tx_len", txq1[0], 8'h01);
            check("post_rst tx_byte", txq1[1], 8'h00);
        end

        // ECHO_LEN=0 instance: ciphertext only
        txq2.delete();
        for (int k = 0; k < vecs[3].nrx; k++) rx_byte(2, vecs[3].rx[k]);
        wait_done(2, 3000, "noecho");
        check("noecho tx_count", txq2.size(), 4);
        for (int k = 0; k < 4 && k < txq2.size(); k++)
            check($sformatf("noecho tx_byte[%0d]", k), txq2[k], vecs[3].tx[k+1]);
        check("noecho error", error2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
